// File: rtl/cdb_scheduler_pkg.sv
// Shared out-of-order core package.
// Holds the default ROB tag and result widths plus the packed CDB payload
// type {robid, value}, used by the CDB scheduler, the ROB and the
// reservation stations so that all of them agree on the broadcast format.
package cdb_scheduler_pkg;

    localparam int ROBID_BITS = 7;
    localparam int VALUE_SIZE = 32;

    typedef struct packed {
        logic [ROBID_BITS-1:0] robid;
        logic [VALUE_SIZE-1:0] value;
    } cdb_pkt_t;

    // Even parity over a CDB payload, for consumers that protect the bus.
    function automatic logic cdb_parity(input cdb_pkt_t pkt);
        return ^pkt;
    endfunction

endpackage

// File: rtl/cdb_scheduler_rr_picker.sv
// Masked round-robin priority picker.
// Starting at index ptr and walking upward with wrap-around modulo NUM_REQ,
// the first set bit of req wins.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index that currently has highest priority (always < NUM_REQ)
//   grant - one-hot grant (all zero when req is all zero)
//   any   - at least one request is present
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               any
);

    logic [NUM_REQ-1:0] grant_s;
    logic               any_s;
    int                 idx_s;

    // Walk the requesters in priority order from ptr; modulo keeps the
    // wrap correct for non-power-of-two NUM_REQ.
    always_comb begin
        grant_s = '0;
        any_s   = 1'b0;
        idx_s   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx_s = (int'(ptr) + i) % NUM_REQ;
            if (!any_s && req[idx_s]) begin
                grant_s[idx_s] = 1'b1;
                any_s          = 1'b1;
            end else begin
                any_s = any_s;
            end
        end
    end

    assign grant = grant_s;
    assign any   = any_s;

endmodule

// File: rtl/cdb_scheduler.sv
// Common data bus scheduler.
// Arbitrates round-robin among NUM_REQ functional units and holds the
// winning result in a one-entry output register that drives the CDB.
// A held broadcast that is consumed (cdb_ready) frees the slot in the same
// cycle, so a new grant can be issued without a bubble. flush squashes the
// held broadcast and blocks grants for that cycle.
// Ports:
//   clk, rst              - clock (rising edge), async active-low reset
//   req_valid/robid/value - per-requester results (packed, slice i = req i)
//   req_ready             - one-hot combinational grant
//   cdb_ready             - downstream consumes the CDB this cycle
//   flush                 - mispredict squash
//   cdb_valid/robid/value/src - registered broadcast and its owner index
module cdb_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int ROBID_BITS = cdb_scheduler_pkg::ROBID_BITS,
    parameter int VALUE_SIZE = cdb_scheduler_pkg::VALUE_SIZE,
    parameter int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ROBID_BITS-1:0] req_robid,
    input  logic [NUM_REQ*VALUE_SIZE-1:0] req_value,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          cdb_ready,
    input  logic                          flush,
    output logic                          cdb_valid,
    output logic [ROBID_BITS-1:0]         cdb_robid,
    output logic [VALUE_SIZE-1:0]         cdb_value,
    output logic [SRC_W-1:0]              cdb_src
);

    logic [SRC_W-1:0]      rr_ptr_r;
    logic                  cdb_valid_r;
    logic [ROBID_BITS-1:0] cdb_robid_r;
    logic [VALUE_SIZE-1:0] cdb_value_r;
    logic [SRC_W-1:0]      cdb_src_r;

    logic [NUM_REQ-1:0]    pick_grant_s;
    logic                  pick_any_s;
    logic                  slot_free_s;
    logic                  grant_en_s;
    logic                  grant_fire_s;
    logic [NUM_REQ-1:0]    req_ready_s;
    logic [SRC_W-1:0]      grant_idx_s;
    logic [ROBID_BITS-1:0] grant_robid_s;
    logic [VALUE_SIZE-1:0] grant_value_s;
    logic [SRC_W-1:0]      next_ptr_s;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (SRC_W)
    ) u_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_r),
        .grant (pick_grant_s),
        .any   (pick_any_s)
    );

    // Slot is free when empty or when the held entry is consumed this cycle.
    assign slot_free_s  = !cdb_valid_r || cdb_ready;
    assign grant_en_s   = slot_free_s && !flush && rst;
    assign grant_fire_s = grant_en_s && pick_any_s;

    // Gate the picker result; req_ready stays low during reset and flush.
    always_comb begin
        if (grant_en_s) begin
            req_ready_s = pick_grant_s;
        end else begin
            req_ready_s = '0;
        end
    end

    assign req_ready = req_ready_s;

    // Encode the one-hot grant and mux out the winner's tag and value.
    always_comb begin
        grant_idx_s   = '0;
        grant_robid_s = '0;
        grant_value_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_grant_s[i]) begin
                grant_idx_s   = SRC_W'(i);
                grant_robid_s = req_robid[i*ROBID_BITS +: ROBID_BITS];
                grant_value_s = req_value[i*VALUE_SIZE +: VALUE_SIZE];
            end else begin
                grant_idx_s = grant_idx_s;
            end
        end
    end

    // Pointer moves one past the winner, wrapping at NUM_REQ-1.
    always_comb begin
        if (grant_idx_s == SRC_W'(NUM_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = grant_idx_s + SRC_W'(1);
        end
    end

    // Output register and round-robin pointer; flush beats cdb_ready and grants.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cdb_valid_r <= 1'b0;
            cdb_robid_r <= '0;
            cdb_value_r <= '0;
            cdb_src_r   <= '0;
            rr_ptr_r    <= '0;
        end else if (flush) begin
            cdb_valid_r <= 1'b0;
        end else if (grant_fire_s) begin
            cdb_valid_r <= 1'b1;
            cdb_robid_r <= grant_robid_s;
            cdb_value_r <= grant_value_s;
            cdb_src_r   <= grant_idx_s;
            rr_ptr_r    <= next_ptr_s;
        end else if (slot_free_s) begin
            cdb_valid_r <= 1'b0;
        end else begin
            cdb_valid_r <= cdb_valid_r;
        end
    end

    assign cdb_valid = cdb_valid_r;
    assign cdb_robid = cdb_robid_r;
    assign cdb_value = cdb_value_r;
    assign cdb_src   = cdb_src_r;

endmodule

// File: tb/tb_cdb_scheduler.sv
module tb_cdb_scheduler;

    logic        clk;
    logic        rst;

    // NUM_REQ = 4 instance
    logic [3:0]   req_valid;
    logic [27:0]  req_robid;
    logic [127:0] req_value;
    logic [3:0]   req_ready;
    logic         cdb_ready;
    logic         flush;
    logic         cdb_valid;
    logic [6:0]   cdb_robid;
    logic [31:0]  cdb_value;
    logic [1:0]   cdb_src;

    // NUM_REQ = 3 instance for the non-power-of-two wrap
    logic [2:0]   req_valid3;
    logic [20:0]  req_robid3;
    logic [95:0]  req_value3;
    logic [2:0]   req_ready3;
    logic         cdb_ready3;
    logic         flush3;
    logic         cdb_valid3;
    logic [6:0]   cdb_robid3;
    logic [31:0]  cdb_value3;
    logic [1:0]   cdb_src3;

    int checks;
    int errors;

    cdb_scheduler dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_robid(req_robid), .req_value(req_value),
        .req_ready(req_ready), .cdb_ready(cdb_ready), .flush(flush),
        .cdb_valid(cdb_valid), .cdb_robid(cdb_robid), .cdb_value(cdb_value),
        .cdb_src(cdb_src)
    );

    cdb_scheduler #(.NUM_REQ(3)) dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_robid(req_robid3), .req_value(req_value3),
        .req_ready(req_ready3), .cdb_ready(cdb_ready3), .flush(flush3),
        .cdb_valid(cdb_valid3), .cdb_robid(cdb_robid3), .cdb_value(cdb_value3),
        .cdb_src(cdb_src3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] valid;
        logic       rdy;
        logic       fl;
        logic [3:0] exp_ready;
        logic       exp_valid;
        logic [1:0] exp_src;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] tag_of(input int i);
        return 7'(10 + i);
    endfunction

    function automatic logic [31:0] val_of(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    vec_t vecs[16];

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        req_valid = 4'b0000; cdb_ready = 1'b1; flush = 1'b0;
        req_valid3 = 3'b000; cdb_ready3 = 1'b1; flush3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_robid[i*7 +: 7]   = tag_of(i);
            req_value[i*32 +: 32] = val_of(i);
        end
        for (int i = 0; i < 3; i++) begin
            req_robid3[i*7 +: 7]   = tag_of(i);
            req_value3[i*32 +: 32] = val_of(i);
        end

        // Reset state
        #2;
        chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
        chk("rst_cdb_robid", 64'(cdb_robid), 64'd0);
        chk("rst_cdb_value", 64'(cdb_value), 64'd0);
        chk("rst_cdb_src",   64'(cdb_src),   64'd0);
        req_valid = 4'b1111;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = 4'b0000;
        @(negedge clk);
        rst = 1'b1;

        // Wrap on NUM_REQ=3: req2 then req0 back to back
        @(negedge clk);
        req_valid3 = 3'b100;
        #1;
        chk("wrap3_grant2", 64'(req_ready3), 64'b100);
        @(posedge clk); #1;
        chk("wrap3_src2", 64'(cdb_src3), 64'd2);
        chk("wrap3_valid2", 64'(cdb_valid3), 64'd1);
        @(negedge clk);
        req_valid3 = 3'b001;
        #1;
        chk("wrap3_grant0_nobubble", 64'(req_ready3), 64'b001);
        @(posedge clk); #1;
        chk("wrap3_src0", 64'(cdb_src3), 64'd0);
        chk("wrap3_robid0", 64'(cdb_robid3), 64'(tag_of(0)));
        @(negedge clk);
        req_valid3 = 3'b101;
        #1;
        chk("wrap3_ptr1_pick2", 64'(req_ready3), 64'b100);
        @(negedge clk);
        req_valid3 = 3'b000;

        // Table-driven main sequence on the 4-requester instance (ptr starts 0)
        vecs[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0};
        vecs[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1};
        vecs[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2};
        vecs[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3};
        vecs[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0};
        vecs[5]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};   // idle drop
        vecs[6]  = '{4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1};   // ptr still 1
        vecs[7]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1};   // held
        vecs[8]  = '{4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[9]  = '{4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0};   // pass-through
        vecs[10] = '{4'b0110, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd0};   // flush
        vecs[11] = '{4'b0110, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1};   // ptr unchanged
        vecs[12] = '{4'b0110, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd1};
        vecs[13] = '{4'b0110, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2};
        vecs[14] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0};   // flush beats hold
        vecs[15] = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd3};

        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            req_valid = vecs[n].valid;
            cdb_ready = vecs[n].rdy;
            flush     = vecs[n].fl;
            #1;
            chk($sformatf("vec%0d_req_ready", n), 64'(req_ready), 64'(vecs[n].exp_ready));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_cdb_valid", n), 64'(cdb_valid), 64'(vecs[n].exp_valid));
            if (vecs[n].exp_valid) begin
                chk($sformatf("vec%0d_cdb_src", n), 64'(cdb_src), 64'(vecs[n].exp_src));
                chk($sformatf("vec%0d_cdb_robid", n), 64'(cdb_robid), 64'(tag_of(int'(vecs[n].exp_src))));
                chk($sformatf("vec%0d_cdb_value", n), 64'(cdb_value), 64'(val_of(int'(vecs[n].exp_src))));
            end
        end
        // cdb now holds src3 valid, ptr = 0

        // Reset mid-broadcast clears everything at once
        @(negedge clk);
        req_valid = 4'b0000; cdb_ready = 1'b0; flush = 1'b0;
        #1;
        chk("pre_rst_valid", 64'(cdb_valid), 64'd1);
        rst = 1'b0;
        req_valid = 4'b0110;
        #1;
        chk("midrst_valid", 64'(cdb_valid), 64'd0);
        chk("midrst_robid", 64'(cdb_robid), 64'd0);
        chk("midrst_value", 64'(cdb_value), 64'd0);
        chk("midrst_src",   64'(cdb_src),   64'd0);
        chk("midrst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        cdb_ready = 1'b1;
        #1;
        chk("postrst_lowest", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        chk("postrst_src", 64'(cdb_src), 64'd1);

        // Backpressure: req0 robid 5 / DEADBEEF held for 3 stalled cycles
        @(negedge clk);
        req_robid[6:0]  = 7'd5;
        req_value[31:0] = 32'hDEAD_BEEF;
        req_valid = 4'b0001;
        cdb_ready = 1'b1;
        #1;
        chk("bp_grant0", 64'(req_ready), 64'b0001);
        @(negedge clk);
        req_valid = 4'b0011;
        cdb_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_ready", c), 64'(req_ready), 64'd0);
            chk($sformatf("bp%0d_valid", c), 64'(cdb_valid), 64'd1);
            chk($sformatf("bp%0d_robid", c), 64'(cdb_robid), 64'd5);
            chk($sformatf("bp%0d_value", c), 64'(cdb_value), 64'hDEAD_BEEF);
            chk($sformatf("bp%0d_src", c),   64'(cdb_src),   64'd0);
            @(negedge clk);
        end
        cdb_ready = 1'b1;
        #1;
        chk("bp_release_grant1", 64'(req_ready), 64'b0010);
        @(posedge clk); #1;
        chk("bp_release_src", 64'(cdb_src), 64'd1);
        chk("bp_release_robid", 64'(cdb_robid), 64'(tag_of(1)));
        @(negedge clk);
        req_valid = 4'b0000;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_scheduler.md
CDB_SCHEDULER -- requirements
Module: cdb_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of functional-unit requesters (ALU, MEM, BRANCH, spare).
REQ-002 SHALL have parameter ROBID_BITS, default 7, meaning the width of a ROB tag.
REQ-003 SHALL have parameter VALUE_SIZE, default 32, meaning the width of a result value.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits: requester i has a result to broadcast.
REQ-007 SHALL have port req_robid, input, NUM_REQ*ROBID_BITS bits: packed tags; slice i belongs to requester i.
REQ-008 SHALL have port req_value, input, NUM_REQ*VALUE_SIZE bits: packed results; slice i belongs to requester i.
REQ-009 SHALL have port req_ready, output, NUM_REQ bits: one-hot grant; the result is taken this cycle.
REQ-010 SHALL have port cdb_ready, input, 1 bit: the ROB and stations can consume the CDB this cycle.
REQ-011 SHALL have port flush, input, 1 bit: mispredict squash.
REQ-012 SHALL have port cdb_valid, output, 1 bit: the CDB carries a live broadcast.
REQ-013 SHALL have port cdb_robid, output, ROBID_BITS bits: the broadcast tag.
REQ-014 SHALL have port cdb_value, output, VALUE_SIZE bits: the broadcast value.
REQ-015 SHALL have port cdb_src, output, clog2(NUM_REQ) bits: the index of the requester that owns the broadcast.

Function
REQ-016 SHALL hold the CDB in an output register of one entry; cdb_* are driven only from flops.
REQ-017 SHALL treat the slot as free when cdb_valid=0, or when cdb_valid=1 and cdb_ready=1 (pass-through in the same cycle).
REQ-018 SHALL, when the slot is free and flush=0, grant exactly one valid requester, chosen round-robin starting at pointer rr_ptr; a requester with req_valid=1 is always eligible.
REQ-019 SHALL assert req_ready combinationally in the grant cycle; the handshake completes when req_valid&req_ready; a requester holds its robid and value stable until it is granted.
REQ-020 SHALL load the granted robid, value and index into the output register at the next edge, giving 1-cycle latency from grant to cdb_valid.
REQ-021 SHALL, on a completed grant to index k, set rr_ptr to (k+1) mod NUM_REQ; otherwise rr_ptr holds.
REQ-022 SHALL, when the slot is not free (cdb_valid=1, cdb_ready=0), drive req_ready=0 and hold cdb_* unchanged.
REQ-023 SHALL clear cdb_valid at the next edge when cdb_ready=1 and no grant occurs.
REQ-024 SHALL, when flush=1, drive req_ready=0 in that cycle, clear cdb_valid at the next edge and leave rr_ptr unchanged; flush has priority over cdb_ready and grants.
REQ-025 SHALL never issue a grant when req_valid is all zero; no requester waits more than NUM_REQ-1 grants.
REQ-026 SHALL give rr_ptr wrap-around modulo NUM_REQ, correct for non-power-of-two NUM_REQ.

Reset
REQ-027 SHALL, while rst=0, asynchronously force cdb_valid=0, cdb_robid=0, cdb_value=0, cdb_src=0 and rr_ptr=0; req_ready SHALL be 0 while rst=0.
REQ-028 SHALL, when reset asserts mid-broadcast, discard the held result; there is no replay.

Structure
REQ-029 SHALL place ROBID_BITS, VALUE_SIZE and the packed CDB struct type {robid, value} in the shared OOO package, used also by the ROB and res_station.
REQ-030 SHALL implement the masked round-robin priority pick as one sub-module, rr_picker (inputs req and ptr; outputs one-hot grant and any).

Verification
REQ-031 Reset: rst=0 mid-broadcast -> all cdb_* = 0 and req_ready=0 immediately; after release, first grant goes to the lowest valid index.
REQ-032 Round-robin: all 4 req_valid=1 held, cdb_ready=1 -> grants 0,1,2,3,0; cdb_src follows the same sequence, one per cycle.
REQ-033 Backpressure: req0 robid=5 value=0xDEADBEEF granted, cdb_ready=0 for 3 cycles -> cdb_* stable and req_ready=0; the cycle cdb_ready=1 -> the next requester is granted in the same cycle.
REQ-034 Flush: cdb_valid=1 with req1 and req2 valid, flush=1 -> no req_ready that cycle, cdb_valid=0 next, rr_ptr unchanged.
REQ-035 Wrap: NUM_REQ=3, only req2 valid then only req0 -> rr_ptr goes 0->0 after the req2 grant; the req0 grant follows without a bubble.
REQ-036 Idle: req_valid=0 with cdb_ready=1 -> cdb_valid drops after one cycle and rr_ptr is unchanged.
